// File: rtl/single_port_ram_sync.sv
// Single-port synchronous RAM: one shared address, registered read data,
// asynchronous active-high reset that clears the array and the output register.
module single_port_ram_sync #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out
);

  localparam int depth = 2 ** addr_width;

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] mem_d [depth];
  logic [data_width-1:0] data_out_q;
  logic [data_width-1:0] data_out_d;

  // A write cycle leaves data_out holding its last read value.
  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    if (we) begin
      mem_d[addr] = data_in;
    end else begin
      data_out_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram_sync.sv
// Directed self-checking bench for single_port_ram_sync (8-bit x 16 default).
module tb_single_port_ram_sync;

  logic       clk;
  logic       rst;
  logic       we;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  single_port_ram_sync #(.data_width(8), .addr_width(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    @(negedge clk);
    we = 1'b0; addr = a; data_in = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; addr = 4'd0; data_in = 8'h00;
    #12;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_out: got %h want 00", data_out);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i += 5) begin
      do_read(i[3:0]);
      checks++;
      if (data_out !== 8'h00) begin
        errors++; $display("FAIL reset_mem[%0d]: got %h want 00", i, data_out);
      end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h56; exp[2] = 8'hB4;
    for (int i = 0; i < 3; i++) do_write(i[3:0], exp[i]);
    for (int i = 0; i < 3; i++) begin
      do_read(i[3:0]);
      checks++;
      if (data_out !== exp[i]) begin
        errors++; $display("FAIL readback[%0d]: got %h want %h", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_hold_on_write;
    do_read(4'd0);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL hold_pre: got %h want a5", data_out);
    end
    do_write(4'd5, 8'h3C);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL hold_during_write: got %h want a5", data_out);
    end
    do_read(4'd5);
    checks++;
    if (data_out !== 8'h3C) begin
      errors++; $display("FAIL read_after_write: got %h want 3c", data_out);
    end
  endtask

  task automatic test_overwrite;
    do_write(4'd3, 8'h11);
    do_write(4'd3, 8'h22);
    do_read(4'd3);
    checks++;
    if (data_out !== 8'h22) begin
      errors++; $display("FAIL overwrite: got %h want 22", data_out);
    end
  endtask

  task automatic test_boundary;
    do_write(4'd15, 8'hFF);
    do_write(4'd0, 8'h01);
    do_read(4'd15);
    checks++;
    if (data_out !== 8'hFF) begin
      errors++; $display("FAIL boundary_15: got %h want ff", data_out);
    end
    do_read(4'd0);
    checks++;
    if (data_out !== 8'h01) begin
      errors++; $display("FAIL boundary_0: got %h want 01", data_out);
    end
  endtask

  task automatic test_mid_cycle;
    do_read(4'd1);
    checks++;
    if (data_out !== 8'h56) begin
      errors++; $display("FAIL midcycle_pre: got %h want 56", data_out);
    end
    // Glitch the inputs between edges, then restore before the next rising edge.
    we = 1'b1; addr = 4'd2; data_in = 8'hEE;
    #2;
    checks++;
    if (data_out !== 8'h56) begin
      errors++; $display("FAIL midcycle_out: got %h want 56", data_out);
    end
    we = 1'b0; addr = 4'd1; data_in = 8'h00;
    do_read(4'd2);
    checks++;
    if (data_out !== 8'hB4) begin
      errors++; $display("FAIL midcycle_mem: got %h want b4", data_out);
    end
  endtask

  task automatic test_async_reset;
    checks++;
    if (data_out !== 8'hB4) begin
      errors++; $display("FAIL areset_pre: got %h want b4", data_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL areset_immediate: got %h want 00", data_out);
    end
    // A write presented during reset must be ignored.
    we = 1'b1; addr = 4'd9; data_in = 8'h77;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    do_read(4'd2);
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL areset_mem2: got %h want 00", data_out);
    end
    do_read(4'd9);
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL areset_write_ignored: got %h want 00", data_out);
    end
  endtask

  task automatic test_isolation;
    do_write(4'd7, 8'h5A);
    do_read(4'd6);
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL isolation_6: got %h want 00", data_out);
    end
    do_read(4'd8);
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL isolation_8: got %h want 00", data_out);
    end
    do_read(4'd7);
    checks++;
    if (data_out !== 8'h5A) begin
      errors++; $display("FAIL isolation_7: got %h want 5a", data_out);
    end
  endtask

  task automatic test_idle_hold;
    @(negedge clk);
    we = 1'b0; addr = 4'd3;
    repeat (40) @(posedge clk);
    do_read(4'd7);
    checks++;
    if (data_out !== 8'h5A) begin
      errors++; $display("FAIL idle_hold: got %h want 5a", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold_on_write();
    test_overwrite();
    test_boundary();
    test_mid_cycle();
    test_async_reset();
    test_isolation();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_port_ram_sync.md
SINGLE_PORT_RAM_SYNC -- requirements
Module: single_port_ram_sync

Interface
REQ-001 SHALL have parameter data_width, default 8, the word width in bits.
REQ-002 SHALL have parameter addr_width, default 4, the address width in bits; depth is 2**addr_width words (16 at default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port we, input, 1 bit: write enable; 1 = write cycle, 0 = read cycle.
REQ-006 SHALL have port addr, input, addr_width bits: word address, shared by read and write.
REQ-007 SHALL have port data_in, input, data_width bits: write data.
REQ-008 SHALL have port data_out, output, data_width bits: registered read data.

Function
REQ-009 SHALL store data_in into mem[addr] on a rising clk edge when we=1 and rst=0.
REQ-010 SHALL load data_out with mem[addr] on a rising clk edge when we=0 and rst=0, giving one-cycle read latency.
REQ-011 SHALL hold data_out unchanged on write cycles (we=1); there is no write-through to data_out.
REQ-012 SHALL leave every word other than mem[addr] unchanged on a write.
REQ-013 SHALL sample addr, we and data_in only at the rising clk edge; mid-cycle changes have no effect.
REQ-014 SHALL treat every addr value 0..2**addr_width-1 as valid; no wrap, decode or range error is possible.
REQ-015 SHALL return the newly written value on a read of an address issued in the cycle after the write to it.
REQ-016 SHALL hold contents indefinitely while idle, with no refresh and no clock-enable dependency.

Reset
REQ-017 SHALL, while rst=1, drive data_out to 0 immediately, without waiting for a clock edge.
REQ-018 SHALL, while rst=1, clear every memory word to 0 and ignore we.
REQ-019 SHALL resume normal operation on the first rising clk edge after rst deasserts.
REQ-020 SHALL abort a write that coincides with rst assertion, leaving the target word at 0.

Structure
REQ-021 SHALL be self-contained; no shared package is required because the only constants are the two parameters.
REQ-022 SHALL contain no sub-modules; storage is one register array plus the data_out register.

Verification
REQ-023 SHALL cover write/read-back: reset, then write 0xA5@0, 0x56@1, 0xB4@2 on consecutive cycles, then read 0, 1, 2 -> data_out = 0xA5, 0x56, 0xB4, each one cycle after its address.
REQ-024 SHALL cover hold-on-write: read 0xA5 from address 0, then write 0x3C@5 -> data_out stays 0xA5 during the write cycle.
REQ-025 SHALL cover overwrite: write 0x11@3, then 0x22@3, then read 3 -> data_out = 0x22.
REQ-026 SHALL cover boundary addresses: write 0xFF@15 and 0x01@0, then read 15 and 0 -> data_out = 0xFF, 0x01.
REQ-027 SHALL cover asynchronous reset: with data_out = 0xB4, assert rst between clk edges -> data_out = 0 at once; read 2 after deassert -> data_out = 0x00.
REQ-028 SHALL cover isolation: write 0x5A@7, then read 6 and 8 -> data_out = 0x00 for both, after reset.
